mips_mem_arbiter: RTL and testbench
===================================

MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8, SHALL set the max consecutive read grants while write request pending (guard build only).
REQ-002 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low; asserted when rst==0 at posedge clk.
REQ-004 i_req, i_addr  input  1/32  instruction-fetch read request and word address.
REQ-005 d_req, d_addr  input  1/32  data read request and address.
REQ-006 w_req, w_addr, w_data, w_byteenable  input  1/32/32/4  write-buffer drain request and payload.
REQ-007 wb_addr_hit  input  1  write buffer holds an entry matching the pending read address.
REQ-008 i_ack, d_ack, w_ack  output  1 each  one-cycle completion pulse per requester.
REQ-009 rdata  output  32  registered read data, valid when i_ack or d_ack is high.
REQ-010 mem_address, mem_read, mem_write, mem_writedata, mem_byteenable  output  32/1/1/32/4  Avalon master.
REQ-011 waitrequest, mem_readdata  input  1/32  Avalon slave response.
REQ-012 busy  output  1  high whenever state != IDLE.

Function
REQ-013 States SHALL be IDLE, GRANT_I, GRANT_D, GRANT_W; the FSM SHALL be one-hot-free 2-bit encoded.
REQ-014 In IDLE the arbiter SHALL select, for the next cycle: w if wb_addr_hit and w_req; else i if i_req; else d if d_req; else w if w_req; else stay IDLE.
REQ-015 A request seen in IDLE at edge N SHALL drive its Avalon command from cycle N+1.
REQ-016 In GRANT_I/GRANT_D mem_read SHALL be 1, mem_write 0, mem_byteenable 4'b1111, mem_address the granted address.
REQ-017 In GRANT_W mem_write SHALL be 1, mem_read 0, mem_address/mem_writedata/mem_byteenable taken from w_*.
REQ-018 In IDLE mem_read and mem_write SHALL be 0; mem_address SHALL be 0.
REQ-019 Command signals SHALL be held stable while waitrequest==1.
REQ-020 Grant SHALL complete at the first edge with waitrequest==0; the FSM SHALL return to IDLE (one idle cycle between transactions).
REQ-021 On read completion rdata SHALL capture mem_readdata and the matching ack SHALL pulse in the following cycle; w_ack SHALL pulse the cycle after write completion.
REQ-022 Requesters SHALL hold req and payload until ack; the arbiter SHALL not re-check req after grant (dropped req mid-grant still completes the bus transaction and acks).
REQ-023 A requester SHALL never receive two acks for one transaction; acks SHALL be mutually exclusive.
REQ-024 Simultaneous i_req, d_req, w_req with wb_addr_hit=0 SHALL grant order i, d, w across successive idle arbitrations if all remain asserted.

Reset
REQ-025 With rst==0: state IDLE, all acks 0, rdata 0, mem_read 0, mem_write 0, busy 0, starvation counter 0.
REQ-026 Reset asserted mid-transaction SHALL abort it at that edge without ack; outputs SHALL reach reset values the following cycle.

Configuration
REQ-027 Macro MIPS_ARB_STARVE_GUARD_EN defined: a counter SHALL count read grants issued while w_req is high, clear on a W grant or w_req low; at STARVE_LIMIT, IDLE SHALL grant w ahead of i and d.
REQ-028 Macro undefined: no counter; pure priority of REQ-014 (writes may starve).

Structure
REQ-029 The state enum and a requester-id enum (REQ_I, REQ_D, REQ_W) SHALL live in the shared package mips_cache_pkg.
REQ-030 Priority selection SHALL be a sub-module mips_arb_priority_sel (combinational select of next grant from requests, hit and starve flag); FSM and datapath stay in the top.

Verification
REQ-031 i_req=1 addr 0x0000_1000, waitrequest 3 cycles, readdata 0xDEADBEEF -> mem_read high 4 cycles, i_ack one cycle later with rdata 0xDEADBEEF.
REQ-032 i_req, d_req, w_req all high, wb_addr_hit=0, waitrequest 0 -> grants I, D, W in order, each separated by one IDLE cycle.
REQ-033 d_req addr 0x40 and w_req addr 0x40, wb_addr_hit=1 -> GRANT_W first, mem_write with w_data 0x12345678/byteenable 4'b0011, then GRANT_D.
REQ-034 Guard build, STARVE_LIMIT=2, i_req and w_req held high -> I, I, W; non-guard build -> W never granted while i_req high.
REQ-035 rst driven 0 during GRANT_D with waitrequest=1 -> no d_ack, mem_read 0 next cycle, state IDLE.

Source files
------------

// File: rtl/mips_cache_pkg.sv
// Shared types for the MIPS memory arbiter: FSM state encoding and requester ids.
package mips_cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    GRANT_W = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ_I = 2'd0,
    REQ_D = 2'd1,
    REQ_W = 2'd2
  } req_id_e;

  function automatic arb_state_e grant_state(req_id_e id);
    case (id)
      REQ_I:   return GRANT_I;
      REQ_D:   return GRANT_D;
      default: return GRANT_W;
    endcase
  endfunction

endpackage

// File: rtl/mips_arb_priority_sel.sv
// Combinational next-grant selection for the memory arbiter.
// A write jumps the queue when its buffer entry aliases a pending read or when reads have starved it.
module mips_arb_priority_sel
  import mips_cache_pkg::*;
(
  input  logic    i_req_i,
  input  logic    d_req_i,
  input  logic    w_req_i,
  input  logic    wb_addr_hit_i,
  input  logic    starve_i,
  output logic    grant_vld_o,
  output req_id_e grant_id_o
);

  always_comb begin
    grant_vld_o = 1'b1;
    grant_id_o  = REQ_I;
    if (w_req_i && (wb_addr_hit_i || starve_i)) begin
      grant_id_o = REQ_W;
    end else if (i_req_i) begin
      grant_id_o = REQ_I;
    end else if (d_req_i) begin
      grant_id_o = REQ_D;
    end else if (w_req_i) begin
      grant_id_o = REQ_W;
    end else begin
      grant_vld_o = 1'b0;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Three-way Avalon memory arbiter (instruction fetch, data read, write-buffer drain).
// Optional write-starvation guard enabled by defining MIPS_ARB_STARVE_GUARD_EN.
module mips_mem_arbiter
  import mips_cache_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        w_req,
  input  logic [31:0] w_addr,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_byteenable,
  input  logic        wb_addr_hit,
  output logic        i_ack,
  output logic        d_ack,
  output logic        w_ack,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        busy
);

  arb_state_e  state_q, state_d;
  logic        sel_vld;
  req_id_e     sel_id;
  logic        starve;
  logic        i_ack_q, d_ack_q, w_ack_q;
  logic [31:0] rdata_q;
  logic        done;

  mips_arb_priority_sel u_sel (
    .i_req_i       (i_req),
    .d_req_i       (d_req),
    .w_req_i       (w_req),
    .wb_addr_hit_i (wb_addr_hit),
    .starve_i      (starve),
    .grant_vld_o   (sel_vld),
    .grant_id_o    (sel_id)
  );

`ifdef MIPS_ARB_STARVE_GUARD_EN
  logic [15:0] starve_cnt_q, starve_cnt_d;
  logic        arb_now;

  assign arb_now = (state_q == IDLE) && sel_vld;

  // Saturates at the limit; any write grant or an idle write buffer restarts the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!w_req || (arb_now && sel_id == REQ_W)) begin
      starve_cnt_d = '0;
    end else if (arb_now && starve_cnt_q < 16'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) starve_cnt_q <= '0;
    else      starve_cnt_q <= starve_cnt_d;
  end

  assign starve = (starve_cnt_q >= 16'(STARVE_LIMIT));
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Requests are not re-checked once granted; a grant ends only on the bus handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_vld) state_d = grant_state(sel_id);
      default: if (!waitrequest) state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    busy           = (state_q != IDLE);
    case (state_q)
      GRANT_I: begin
        mem_read       = 1'b1;
        mem_address    = i_addr;
        mem_byteenable = 4'b1111;
      end
      GRANT_D: begin
        mem_read       = 1'b1;
        mem_address    = d_addr;
        mem_byteenable = 4'b1111;
      end
      GRANT_W: begin
        mem_write      = 1'b1;
        mem_address    = w_addr;
        mem_writedata  = w_data;
        mem_byteenable = w_byteenable;
      end
      default: ;
    endcase
  end

  assign done = (state_q != IDLE) && !waitrequest;

  always_ff @(posedge clk) begin
    if (!rst) begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      w_ack_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      i_ack_q <= done && (state_q == GRANT_I);
      d_ack_q <= done && (state_q == GRANT_D);
      w_ack_q <= done && (state_q == GRANT_W);
      if (done && (state_q != GRANT_W)) rdata_q <= mem_readdata;
    end
  end

  assign i_ack = i_ack_q;
  assign d_ack = d_ack_q;
  assign w_ack = w_ack_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a command/ack scoreboard and a wait-state Avalon slave.
module tb_mips_mem_arbiter;

  localparam int MODE_NONE = 0;
  localparam int MODE_SB   = 1;
  localparam int MODE_HOLD = 2;
`ifdef MIPS_ARB_STARVE_GUARD_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } cmd_t;

  typedef struct packed {
    logic [2:0]  vec;
    logic [31:0] data;
  } ack_t;

  logic        clk, rst;
  logic        i_req, d_req, w_req, wb_addr_hit;
  logic [31:0] i_addr, d_addr, w_addr, w_data;
  logic [3:0]  w_byteenable;
  logic        i_ack, d_ack, w_ack;
  logic [31:0] rdata, mem_address, mem_writedata, mem_readdata;
  logic        mem_read, mem_write, waitrequest, busy;
  logic [3:0]  mem_byteenable;

  cmd_t cmd_q[$];
  ack_t ack_q[$];
  int   n_cmp, n_err;
  int   mode, cyc, last_end, wait_left, cfg_wait, rd_cycles, n_done;
  bit   in_xfer, drop_on_ack, gap_chk;

  mips_mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .d_req          (d_req),
    .d_addr         (d_addr),
    .w_req          (w_req),
    .w_addr         (w_addr),
    .w_data         (w_data),
    .w_byteenable   (w_byteenable),
    .wb_addr_hit    (wb_addr_hit),
    .i_ack          (i_ack),
    .d_ack          (d_ack),
    .w_ack          (w_ack),
    .rdata          (rdata),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .waitrequest    (waitrequest),
    .mem_readdata   (mem_readdata),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic hold_exp_wr(int n);
    return STARVE_ON && ((n % 3) == 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cmd_t c;
    c.wr = wr; c.addr = a; c.data = d; c.be = be;
    cmd_q.push_back(c);
  endtask

  task automatic push_ack(input logic [2:0] vec, input logic [31:0] d);
    ack_t e;
    e.vec = vec; e.data = d;
    ack_q.push_back(e);
  endtask

  // One clock: sample DUT 2ns after the edge, score acks/commands, then drive the slave response.
  task automatic cycle();
    logic cmd;
    ack_t e;
    cmd_t c;
    @(posedge clk);
    #2;
    cyc++;
    cmd = mem_read | mem_write;
    check("busy_vs_cmd", {31'd0, busy}, {31'd0, cmd});
    check("rd_wr_excl", {31'd0, mem_read & mem_write}, 32'd0);
    if (!cmd) check("idle_addr", mem_address, 32'd0);
    if (i_ack | d_ack | w_ack) begin
      check("ack_onehot", 32'(i_ack) + 32'(d_ack) + 32'(w_ack), 32'd1);
      if (mode == MODE_SB) begin
        if (ack_q.size() == 0) begin
          check("ack_unexpected", {29'd0, i_ack, d_ack, w_ack}, 32'd0);
        end else begin
          e = ack_q.pop_front();
          check("ack_id", {29'd0, i_ack, d_ack, w_ack}, {29'd0, e.vec});
          check("ack_latency", cyc - last_end, 32'd1);
          if (!w_ack) check("ack_rdata", rdata, e.data);
        end
      end else if (mode == MODE_HOLD) begin
        check("hold_no_d_ack", {31'd0, d_ack}, 32'd0);
      end else begin
        check("no_ack_expected", {29'd0, i_ack, d_ack, w_ack}, 32'd0);
      end
      if (drop_on_ack && i_ack) i_req = 1'b0;
      if (drop_on_ack && d_ack) d_req = 1'b0;
      if (drop_on_ack && w_ack) begin w_req = 1'b0; wb_addr_hit = 1'b0; end
    end
    if (cmd) begin
      if (!in_xfer) begin
        in_xfer = 1'b1;
        wait_left = cfg_wait;
        rd_cycles = 0;
        if (gap_chk && last_end >= 0) check("idle_gap", cyc - last_end, 32'd2);
      end
      if (mem_read) rd_cycles++;
      waitrequest = (wait_left != 0);
      if (wait_left != 0) wait_left--;
      mem_readdata = rd_model(mem_address);
      if (mode == MODE_SB) begin
        if (cmd_q.size() == 0) begin
          check("cmd_unexpected", {30'd0, mem_read, mem_write}, 32'd0);
        end else begin
          c = cmd_q[0];
          check("cmd_write", {31'd0, mem_write}, {31'd0, c.wr});
          check("cmd_read", {31'd0, mem_read}, {31'd0, ~c.wr});
          check("cmd_addr", mem_address, c.addr);
          check("cmd_be", {28'd0, mem_byteenable}, {28'd0, c.be});
          if (c.wr) check("cmd_wdata", mem_writedata, c.data);
        end
      end
      if (!waitrequest) begin
        last_end = cyc;
        if (mode == MODE_SB && cmd_q.size() != 0) void'(cmd_q.pop_front());
        if (mode == MODE_HOLD) begin
          check("hold_grant_kind", {31'd0, mem_write}, {31'd0, hold_exp_wr(n_done)});
          n_done++;
        end
      end
    end else begin
      in_xfer = 1'b0;
      waitrequest = 1'b0;
    end
  endtask

  task automatic drain(input int max_cycles);
    int k;
    k = 0;
    while ((cmd_q.size() != 0 || ack_q.size() != 0) && k < max_cycles) begin
      cycle();
      k++;
    end
    check("drain_timeout", cmd_q.size() + ack_q.size(), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; last_end = -1; n_done = 0; rd_cycles = 0;
    mode = MODE_NONE; cfg_wait = 0; wait_left = 0; in_xfer = 1'b0;
    drop_on_ack = 1'b1; gap_chk = 1'b0;
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; w_req = 1'b0; wb_addr_hit = 1'b0;
    i_addr = '0; d_addr = '0; w_addr = '0; w_data = '0; w_byteenable = '0;
    waitrequest = 1'b0; mem_readdata = '0;

    // Reset state
    cycle();
    cycle();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_acks", {29'd0, i_ack, d_ack, w_ack}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b1;
    cycle();

    // Single instruction fetch with three wait states
    mode = MODE_SB; cfg_wait = 3;
    push_cmd(1'b0, 32'h0000_1000, 32'd0, 4'b1111);
    push_ack(3'b100, 32'hDEAD_BEEF);
    i_addr = 32'h0000_1000; i_req = 1'b1;
    drain(40);
    check("r31_read_cycles", rd_cycles, 32'd4);
    check("r31_rdata_held", rdata, 32'hDEAD_BEEF);
    cycle();

    // All three requesters at once: I, D, W with one idle cycle between
    cfg_wait = 0; gap_chk = 1'b1; last_end = -1;
    i_addr = 32'h0000_0100; d_addr = 32'h0000_0200; w_addr = 32'h0000_0300;
    w_data = 32'hCAFE_F00D; w_byteenable = 4'b1111;
    push_cmd(1'b0, 32'h0000_0100, 32'd0, 4'b1111);
    push_cmd(1'b0, 32'h0000_0200, 32'd0, 4'b1111);
    push_cmd(1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'b1111);
    push_ack(3'b100, rd_model(32'h0000_0100));
    push_ack(3'b010, rd_model(32'h0000_0200));
    push_ack(3'b001, 32'd0);
    i_req = 1'b1; d_req = 1'b1; w_req = 1'b1;
    drain(40);
    cycle();

    // Write-buffer hit forces the aliasing write ahead of the data read
    last_end = -1; cfg_wait = 1;
    d_addr = 32'h0000_0040; w_addr = 32'h0000_0040;
    w_data = 32'h1234_5678; w_byteenable = 4'b0011;
    push_cmd(1'b1, 32'h0000_0040, 32'h1234_5678, 4'b0011);
    push_cmd(1'b0, 32'h0000_0040, 32'd0, 4'b1111);
    push_ack(3'b001, 32'd0);
    push_ack(3'b010, rd_model(32'h0000_0040));
    d_req = 1'b1; w_req = 1'b1; wb_addr_hit = 1'b1;
    drain(40);
    cycle();

    // Held i_req and w_req: starvation behaviour
    mode = MODE_HOLD; gap_chk = 1'b0; drop_on_ack = 1'b0; cfg_wait = 0; n_done = 0;
    i_addr = 32'h0000_0500; w_addr = 32'h0000_0600; w_byteenable = 4'b1111;
    i_req = 1'b1; w_req = 1'b1;
    repeat (30) cycle();
    for (int k = 0; k < 10 && busy; k++) cycle();
    i_req = 1'b0; w_req = 1'b0;
    check("r34_activity", {31'd0, n_done >= 6}, 32'd1);
    cycle();
    cycle();

    // Reset in the middle of a waiting data read aborts it without an ack
    mode = MODE_NONE; drop_on_ack = 1'b1; cfg_wait = 10;
    d_addr = 32'h0000_0080; d_req = 1'b1;
    cycle();
    check("r35_granted", {31'd0, mem_read}, 32'd1);
    cycle();
    rst = 1'b0;
    cycle();
    check("r35_read_dropped", {31'd0, mem_read}, 32'd0);
    check("r35_idle", {31'd0, busy}, 32'd0);
    check("r35_no_ack", {31'd0, d_ack}, 32'd0);
    check("r35_rdata_reset", rdata, 32'd0);
    d_req = 1'b0;
    rst = 1'b1;
    cycle();
    cycle();
    check("r35_still_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
